// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator for a 640x480@60 DVI/VGA frame (defaults). The generator
// produces the pixel position counters and the sync, data-enable and start pulses
// that the pixel/draw stage consumes. xpos==0 && ypos==0 marks the first active pixel.
//
// Ports
//   clk         in   1   pixel clock
//   rst         in   1   synchronous active-high reset
//   ce          in   1   pixel enable; all state holds while low
//   xpos        out  10  horizontal position, 0..H_TOTAL-1
//   ypos        out  10  vertical position, 0..V_TOTAL-1
//   hsync       out  1   horizontal sync, asserted level = SYNC_POL
//   vsync       out  1   vertical sync, asserted level = SYNC_POL
//   de          out  1   high inside the visible window
//   line_start  out  1   single-cycle pulse at xpos==0
//   frame_start out  1   single-cycle pulse at xpos==0 && ypos==0
//   pattern     out  24  RGB888 colour bars (only with VGA_TIMING_TEST_PATTERN_EN)
//
// Optional feature: define VGA_TIMING_TEST_PATTERN_EN to build the colour-bar
// test pattern output.
//
// Every output is registered from the next counter values, so all outputs describe
// the xpos/ypos presented in the same cycle.

module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   output logic [9:0]  xpos,
   output logic [9:0]  ypos,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        line_start,
`ifdef VGA_TIMING_TEST_PATTERN_EN
   output logic        frame_start,
   output logic [23:0] pattern
`else
   output logic        frame_start
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
         $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
      end
   endgenerate

   localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic       x_last;
   logic       y_last;
   logic [9:0] next_x;
   logic [9:0] next_y;
   logic       next_hsync;
   logic       next_vsync;
   logic       next_de;

   always_comb begin
      x_last     = (xpos == H_MAX);
      y_last     = (ypos == V_MAX);
      next_x     = x_last ? 10'd0 : xpos + 10'd1;
      next_y     = ypos;
      if (x_last) begin
         next_y = y_last ? 10'd0 : ypos + 10'd1;
      end
      next_hsync = (next_x >= HS_START && next_x <= HS_END) ? SYNC_POL : ~SYNC_POL;
      next_vsync = (next_y >= VS_START && next_y <= VS_END) ? SYNC_POL : ~SYNC_POL;
      next_de    = (next_x < H_ACT) && (next_y < V_ACT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         xpos        <= H_MAX;
         ypos        <= V_MAX;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (ce) begin
         xpos        <= next_x;
         ypos        <= next_y;
         hsync       <= next_hsync;
         vsync       <= next_vsync;
         de          <= next_de;
         line_start  <= (next_x == 10'd0);
         frame_start <= (next_x == 10'd0) && (next_y == 10'd0);
      end else begin
         // Pulses are dropped while stalled so each position emits them only once.
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

`ifdef VGA_TIMING_TEST_PATTERN_EN
   // Bars are tracked with a width counter restarted at the line start, which
   // avoids dividing xpos by the bar width. bar_idx wraps past the visible
   // region, which is harmless because the colour is gated by de.
   localparam logic [9:0] BAR_MAX = 10'((H_ACTIVE / 8) - 1);

   logic [9:0]  bar_cnt;
   logic [2:0]  bar_idx;
   logic [9:0]  next_bar_cnt;
   logic [2:0]  next_bar_idx;
   logic [23:0] next_pattern;

   always_comb begin
      next_bar_cnt = bar_cnt + 10'd1;
      next_bar_idx = bar_idx;
      if (next_x == 10'd0) begin
         next_bar_cnt = 10'd0;
         next_bar_idx = 3'd0;
      end else if (bar_cnt == BAR_MAX) begin
         next_bar_cnt = 10'd0;
         next_bar_idx = bar_idx + 3'd1;
      end
      case (next_bar_idx)
         3'd0:    next_pattern = 24'hFFFFFF;
         3'd1:    next_pattern = 24'hFFFF00;
         3'd2:    next_pattern = 24'h00FFFF;
         3'd3:    next_pattern = 24'h00FF00;
         3'd4:    next_pattern = 24'hFF00FF;
         3'd5:    next_pattern = 24'hFF0000;
         3'd6:    next_pattern = 24'h0000FF;
         default: next_pattern = 24'h000000;
      endcase
      if (!next_de) begin
         next_pattern = 24'h000000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bar_cnt <= 10'd0;
         bar_idx <= 3'd0;
         pattern <= 24'h000000;
      end else if (ce) begin
         bar_cnt <= next_bar_cnt;
         bar_idx <= next_bar_idx;
         pattern <= next_pattern;
      end
   end
`endif

endmodule
